// File: rtl/dm_responder_pkg.sv
// rtl/dm_responder_pkg.sv - shared encodings, sizes and lane-placement helpers for dm_responder
package dm_responder_pkg;

   typedef enum logic [1:0] {
      LEN_WORD = 2'b00,
      LEN_HALF = 2'b01,
      LEN_BYTE = 2'b10,
      LEN_RSVD = 2'b11
   } dm_len_e;

   localparam int DM_DEPTH = 1024;
   localparam int DM_AW    = 10;

   typedef struct packed {
      logic [3:0]  be;
      logic [31:0] data;
   } wr_lanes_t;

   // Right-aligned write data is replicated so every candidate lane holds it; be picks the lane.
   function automatic wr_lanes_t place_lanes(input logic [1:0] len, input logic [1:0] off,
                                             input logic [31:0] wdata);
      wr_lanes_t r;
      r.be   = 4'b0000;
      r.data = 32'h0;
      case (dm_len_e'(len))
         LEN_WORD: begin
            r.be   = 4'b1111;
            r.data = wdata;
         end
         LEN_HALF: begin
            r.be   = off[1] ? 4'b1100 : 4'b0011;
            r.data = {2{wdata[15:0]}};
         end
         LEN_BYTE: begin
            r.be   = 4'b0001 << off;
            r.data = {4{wdata[7:0]}};
         end
         default: begin
            r.be   = 4'b0000;
            r.data = 32'h0;
         end
      endcase
      return r;
   endfunction

   function automatic logic len_aligned(input logic [1:0] len, input logic [1:0] off);
      case (dm_len_e'(len))
         LEN_WORD: return off == 2'b00;
         LEN_HALF: return !off[0];
         LEN_BYTE: return 1'b1;
         default:  return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/dm_ram.sv
// rtl/dm_ram.sv - 1024x32 data RAM, asynchronous read, byte-enable synchronous write, no reset
module dm_ram
   import dm_responder_pkg::*;
(
   input  logic             clk,
   input  logic             we,
   input  logic [DM_AW-1:0] waddr,
   input  logic [3:0]       be,
   input  logic [31:0]      wdata,
   input  logic [DM_AW-1:0] raddr,
   output logic [31:0]      rdata
);

   logic [31:0] mem [DM_DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/dm_responder.sv
// rtl/dm_responder.sv - data memory responder with a 1-entry posted write buffer and read forwarding
module dm_responder
   import dm_responder_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] DMAdr,
   input  logic        DMWE,
   input  logic [31:0] DMDataW,
   input  logic [1:0]  DMWLen,
   output logic [31:0] DMDataR,
   output logic        DMErr,
   output logic [31:0] DMErrAdr
);

   logic [DM_AW-1:0] idx;
   logic [1:0]       off;
   wr_lanes_t        lanes;
   logic             accept;
   logic             reject;

   logic             wb_valid;
   logic [DM_AW-1:0] wb_idx;
   logic [3:0]       wb_be;
   logic [31:0]      wb_data;
   logic [31:0]      ram_rdata;

   assign idx = DMAdr[DM_AW+1:2];
   assign off = DMAdr[1:0];

   always_comb begin
      lanes  = place_lanes(DMWLen, off, DMDataW);
      accept = DMWE && len_aligned(DMWLen, off);
      reject = DMWE && !accept;
   end

   // The RAM is written only from the buffer, so a drain and a new load share one edge.
   dm_ram u_ram (
      .clk   (clk),
      .we    (wb_valid),
      .waddr (wb_idx),
      .be    (wb_be),
      .wdata (wb_data),
      .raddr (idx),
      .rdata (ram_rdata)
   );

   always_comb begin
      DMDataR = ram_rdata;
      for (int i = 0; i < 4; i++) begin
         if (wb_valid && (wb_idx == idx) && wb_be[i]) DMDataR[8*i +: 8] = wb_data[8*i +: 8];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wb_valid <= 1'b0;
         wb_idx   <= '0;
         wb_be    <= 4'b0000;
         wb_data  <= 32'h0;
         DMErr    <= 1'b0;
         DMErrAdr <= 32'h0;
      end else begin
         wb_valid <= accept;
         if (accept) begin
            wb_idx  <= idx;
            wb_be   <= lanes.be;
            wb_data <= lanes.data;
         end
         if (reject) begin
            DMErr <= 1'b1;
            if (!DMErr) DMErrAdr <= DMAdr;
         end
      end
   end

endmodule

// File: tb/tb_dm_responder.sv
// tb/tb_dm_responder.sv - scoreboard bench for dm_responder with directed vectors
module tb_dm_responder;
   import dm_responder_pkg::*;

   logic        clk;
   logic        reset;
   logic [31:0] DMAdr;
   logic        DMWE;
   logic [31:0] DMDataW;
   logic [1:0]  DMWLen;
   logic [31:0] DMDataR;
   logic        DMErr;
   logic [31:0] DMErrAdr;

   dm_responder dut (
      .clk      (clk),
      .reset    (reset),
      .DMAdr    (DMAdr),
      .DMWE     (DMWE),
      .DMDataW  (DMDataW),
      .DMWLen   (DMWLen),
      .DMDataR  (DMDataR),
      .DMErr    (DMErr),
      .DMErrAdr (DMErrAdr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      bit          chk_d;
      logic [31:0] d;
      logic        e;
      logic [31:0] ea;
   } exp_t;

   exp_t exp_q[$];
   logic probe;
   int   total;
   int   bad;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   always @(negedge clk) begin
      if (probe) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard: got empty queue want an expectation");
         end else begin
            exp_t x;
            x = exp_q.pop_front();
            if (x.chk_d) check({x.name, "_data"}, DMDataR, x.d);
            check({x.name, "_err"}, {31'h0, DMErr}, {31'h0, x.e});
            check({x.name, "_erradr"}, DMErrAdr, x.ea);
         end
      end
   end

   task automatic step(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                       input logic [1:0] len);
      @(posedge clk);
      #1;
      probe   = 1'b0;
      DMWE    = we;
      DMAdr   = adr;
      DMDataW = wd;
      DMWLen  = len;
   endtask

   task automatic expect_now(input string name, input bit chk_d, input logic [31:0] d,
                             input logic e, input logic [31:0] ea);
      exp_t x;
      x.name  = name;
      x.chk_d = chk_d;
      x.d     = d;
      x.e     = e;
      x.ea    = ea;
      exp_q.push_back(x);
      probe = 1'b1;
   endtask

   initial begin
      total   = 0;
      bad     = 0;
      probe   = 1'b0;
      reset   = 1'b0;
      DMWE    = 1'b0;
      DMAdr   = 32'h0;
      DMDataW = 32'h0;
      DMWLen  = LEN_WORD;

      step(0, 32'h0, 32'h0, LEN_WORD);
      expect_now("reset_state", 0, 32'h0, 1'b0, 32'h0);
      step(0, 32'h0, 32'h0, LEN_WORD);
      reset = 1'b1;

      // forwarding then RAM
      step(1, 32'h10, 32'hDEADBEEF, LEN_WORD);
      step(0, 32'h10, 32'h0, LEN_WORD);
      expect_now("word_fwd", 1, 32'hDEADBEEF, 1'b0, 32'h0);
      step(0, 32'h10, 32'h0, LEN_WORD);
      expect_now("word_ram", 1, 32'hDEADBEEF, 1'b0, 32'h0);
      step(1, 32'h10, 32'h01020304, LEN_WORD);
      expect_now("no_bypass", 1, 32'hDEADBEEF, 1'b0, 32'h0);
      step(0, 32'h10, 32'h0, LEN_WORD);
      expect_now("new_fwd", 1, 32'h01020304, 1'b0, 32'h0);

      // back-to-back merges into one word
      step(1, 32'h20, 32'h00000000, LEN_WORD);
      step(1, 32'h21, 32'h555555AB, LEN_BYTE);
      step(1, 32'h22, 32'h99991234, LEN_HALF);
      step(0, 32'h20, 32'h0, LEN_WORD);
      expect_now("merge_fwd", 1, 32'h1234AB00, 1'b0, 32'h0);
      step(0, 32'h20, 32'h0, LEN_WORD);
      expect_now("merge_ram", 1, 32'h1234AB00, 1'b0, 32'h0);
      step(1, 32'h23, 32'h000000CD, LEN_BYTE);
      step(0, 32'h20, 32'h0, LEN_WORD);
      expect_now("byte_lane3", 1, 32'hCD34AB00, 1'b0, 32'h0);

      // address aliasing above bit 11
      step(1, 32'h00001004, 32'hCAFEF00D, LEN_WORD);
      step(0, 32'h00000004, 32'h0, LEN_WORD);
      expect_now("alias_fwd", 1, 32'hCAFEF00D, 1'b0, 32'h0);
      step(0, 32'hFFFFF004, 32'h0, LEN_WORD);
      expect_now("alias_ram", 1, 32'hCAFEF00D, 1'b0, 32'h0);

      // reserved length
      step(0, 32'h50, 32'h0, LEN_RSVD);
      step(0, 32'h50, 32'h0, LEN_WORD);
      expect_now("rsvd_no_we", 0, 32'h0, 1'b0, 32'h0);
      step(1, 32'h50, 32'h50505050, LEN_WORD);
      step(0, 32'h50, 32'h0, LEN_WORD);
      step(1, 32'h50, 32'hBAD0BAD0, LEN_RSVD);
      step(0, 32'h50, 32'h0, LEN_WORD);
      expect_now("rsvd_reject", 1, 32'h50505050, 1'b1, 32'h50);

      // reset while a write is buffered
      step(1, 32'h60, 32'h60606060, LEN_WORD);
      step(0, 32'h60, 32'h0, LEN_WORD);
      step(1, 32'h60, 32'h11111111, LEN_WORD);
      step(0, 32'h60, 32'h0, LEN_WORD);
      #1;
      reset = 1'b0;
      expect_now("reset_mid", 1, 32'h60606060, 1'b0, 32'h0);
      step(0, 32'h60, 32'h0, LEN_WORD);
      reset = 1'b1;
      expect_now("after_reset", 1, 32'h60606060, 1'b0, 32'h0);
      step(0, 32'h60, 32'h0, LEN_WORD);
      expect_now("no_late_drain", 1, 32'h60606060, 1'b0, 32'h0);

      // misaligned writes and sticky error address
      step(1, 32'h30, 32'h33333333, LEN_WORD);
      step(0, 32'h30, 32'h0, LEN_WORD);
      step(1, 32'h31, 32'h0000ABCD, LEN_HALF);
      step(0, 32'h30, 32'h0, LEN_WORD);
      expect_now("half_misalign", 1, 32'h33333333, 1'b1, 32'h31);
      step(1, 32'h42, 32'h77777777, LEN_WORD);
      step(0, 32'h30, 32'h0, LEN_WORD);
      expect_now("erradr_kept", 1, 32'h33333333, 1'b1, 32'h31);
      step(1, 32'h33, 32'h000000EE, LEN_BYTE);
      step(0, 32'h30, 32'h0, LEN_WORD);
      expect_now("byte_after_err", 1, 32'hEE333333, 1'b1, 32'h31);

      step(0, 32'h0, 32'h0, LEN_WORD);
      repeat (2) @(posedge clk);
      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
